// File: rtl/iterative_alu_unit.sv
// Multi-cycle ALU: single-cycle logic/arith ops, 1 bit/cycle shifts and shift-add MUL.
// Latency: 1 cycle (logic/arith/illegal/zero shift), 1+n (shift by n), 1+WIDTH (MUL); holds DONE until resp_ready.
// Backpressure: req_ready only in IDLE; result held stable in DONE while resp_ready is low.
module iterative_alu_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [WIDTH-1:0] req_in_1,
    input  logic [WIDTH-1:0] req_in_2,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_bcond,
    output logic             resp_err
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0111;
    localparam logic [3:0] OP_SRL = 4'b1000;
    localparam logic [3:0] OP_MUL = 4'b1001;

    // One extra bit so the counter can hold WIDTH for MUL.
    localparam int CNT_W = SHAMT_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q,  state_d;
    logic [3:0]         op_q,     op_d;
    logic [WIDTH-1:0]   opa_q,    opa_d;
    logic [WIDTH-1:0]   opb_q,    opb_d;
    logic [WIDTH-1:0]   acc_q,    acc_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               err_q,    err_d;

    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   sll_nxt;
    logic [WIDTH-1:0]   srl_nxt;
    logic [WIDTH-1:0]   mul_acc_nxt;

    assign shamt       = req_in_2[SHAMT_W-1:0];
    assign sll_nxt     = opa_q << 1;
    assign srl_nxt     = opa_q >> 1;
    assign mul_acc_nxt = opb_q[0] ? (acc_q + opa_q) : acc_q;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d  = req_op;
                    err_d = 1'b0;
                    case (req_op)
                        OP_AND: begin
                            result_d = req_in_1 & req_in_2;
                            state_d  = S_DONE;
                        end
                        OP_OR: begin
                            result_d = req_in_1 | req_in_2;
                            state_d  = S_DONE;
                        end
                        OP_ADD: begin
                            result_d = req_in_1 + req_in_2;
                            state_d  = S_DONE;
                        end
                        OP_SUB: begin
                            result_d = req_in_1 - req_in_2;
                            state_d  = S_DONE;
                        end
                        OP_XOR: begin
                            result_d = req_in_1 ^ req_in_2;
                            state_d  = S_DONE;
                        end
                        OP_SLL, OP_SRL: begin
                            if (shamt == '0) begin
                                result_d = req_in_1;
                                state_d  = S_DONE;
                            end else begin
                                opa_d   = req_in_1;
                                cnt_d   = {1'b0, shamt};
                                state_d = S_EXEC;
                            end
                        end
                        OP_MUL: begin
                            opa_d   = req_in_1;
                            opb_d   = req_in_2;
                            acc_d   = '0;
                            cnt_d   = CNT_W'(WIDTH);
                            state_d = S_EXEC;
                        end
                        default: begin
                            result_d = '0;
                            err_d    = 1'b1;
                            state_d  = S_DONE;
                        end
                    endcase
                end
            end

            S_EXEC: begin
                cnt_d = cnt_q - CNT_W'(1);
                case (op_q)
                    OP_SLL:  opa_d = sll_nxt;
                    OP_SRL:  opa_d = srl_nxt;
                    default: begin
                        acc_d = mul_acc_nxt;
                        opa_d = sll_nxt;
                        opb_d = opb_q >> 1;
                    end
                endcase
                // Final iteration writes the result directly so DONE shows it on entry.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                    case (op_q)
                        OP_SLL:  result_d = sll_nxt;
                        OP_SRL:  result_d = srl_nxt;
                        default: result_d = mul_acc_nxt;
                    endcase
                end
            end

            S_DONE: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign resp_valid  = (state_q == S_DONE);
    assign resp_result = result_q;
    assign resp_bcond  = (result_q == '0);
    assign resp_err    = err_q;

endmodule

// File: tb/tb_iterative_alu_unit.sv
// Bench for iterative_alu_unit: directed cases plus a short random mix, scoreboarded.
module tb_iterative_alu_unit;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0111;
    localparam logic [3:0] OP_SRL = 4'b1000;
    localparam logic [3:0] OP_MUL = 4'b1001;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_in_1;
    logic [31:0] req_in_2;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;
    logic        resp_bcond;
    logic        resp_err;

    typedef struct {
        logic [31:0] res;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    iterative_alu_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_in_1    (req_in_1),
        .req_in_2    (req_in_2),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_bcond  (resp_bcond),
        .resp_err    (resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   n;
        n     = int'(b[4:0]);
        e.err = 1'b0;
        e.lat = 1;
        case (op)
            OP_AND: e.res = a & b;
            OP_OR:  e.res = a | b;
            OP_ADD: e.res = a + b;
            OP_SUB: e.res = a - b;
            OP_XOR: e.res = a ^ b;
            OP_SLL: begin e.res = a << n; e.lat = 1 + n; end
            OP_SRL: begin e.res = a >> n; e.lat = 1 + n; end
            OP_MUL: begin e.res = a * b;  e.lat = 33;    end
            default: begin e.res = 32'd0; e.err = 1'b1; end
        endcase
        return e;
    endfunction

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int k;
        k = 0;
        @(negedge clk);
        while (!req_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) chk("issue_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_in_1  = a;
        req_in_2  = b;
        sb.push_back(model(op, a, b));
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Waits for the response, compares against the scoreboard, optionally stalls, then handshakes.
    task automatic wait_resp(input string tag, input int stall);
        exp_t        e;
        int          lat;
        logic [31:0] held;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 100);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
        chk({tag, "_lat"},   32'(lat),        32'(e.lat));
        chk({tag, "_res"},   resp_result,     e.res);
        chk({tag, "_err"},   32'(resp_err),   32'(e.err));
        chk({tag, "_bcond"}, 32'(resp_bcond), 32'(e.res == 32'd0));
        chk({tag, "_rdy_busy"}, 32'(req_ready), 32'd0);
        held = resp_result;
        for (int i = 0; i < stall; i++) begin
            req_valid = 1'b1;
            req_op    = OP_ADD;
            req_in_1  = 32'h1111_0000 + 32'(i);
            req_in_2  = 32'h0000_2222;
            @(negedge clk);
            chk({tag, "_stall_res"},   resp_result,     held);
            chk({tag, "_stall_valid"}, 32'(resp_valid), 32'd1);
            chk({tag, "_stall_rdy"},   32'(req_ready),  32'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_idle_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_idle_rdy"},   32'(req_ready),  32'd1);
        if (stall > 0) chk({tag, "_idle_res"}, resp_result, held);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  ops [10];
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int          seen;

        ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLL, OP_XOR, OP_SRL, OP_MUL, 4'hF, 4'h5};
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 4'd0;
        req_in_1   = 32'd0;
        req_in_2   = 32'd0;
        resp_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_res",   resp_result,     32'd0);
        chk("rst_err",   32'(resp_err),   32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_rdy", 32'(req_ready), 32'd1);

        issue(OP_ADD, 32'd5, 32'd7);                wait_resp("add", 0);
        issue(OP_SUB, 32'd9, 32'd9);                wait_resp("sub_zero", 0);
        issue(OP_SUB, 32'd0, 32'd1);                wait_resp("sub_wrap", 0);
        issue(OP_SLL, 32'd1, 32'd31);               wait_resp("sll31", 0);
        issue(OP_SRL, 32'h8000_0000, 32'd0);        wait_resp("srl0", 0);
        issue(OP_SRL, 32'hF000_000F, 32'd4);        wait_resp("srl4", 0);
        issue(OP_MUL, 32'd7, 32'd6);                wait_resp("mul42", 0);
        issue(OP_MUL, 32'hFFFF_FFFF, 32'd2);        wait_resp("mul_wrap", 0);
        issue(OP_OR, 32'h0F0F_0000, 32'h0000_00F0); wait_resp("bp_or", 10);
        issue(4'hF, 32'h1234_5678, 32'h9ABC_DEF0);  wait_resp("illegal", 0);
        issue(OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0); wait_resp("err_clear", 0);

        // resp_ready held high throughout an iterative op must not cut it short.
        resp_ready = 1'b1;
        issue(OP_SLL, 32'h0000_0003, 32'd5);        wait_resp("rdy_early", 0);

        issue(OP_MUL, 32'd1000, 32'd1000);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_valid", 32'(resp_valid), 32'd0);
        chk("abort_res",   resp_result,     32'd0);
        chk("abort_err",   32'(resp_err),   32'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        seen  = 0;
        repeat (40) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        chk("abort_no_resp", 32'(seen), 32'd0);

        for (int i = 0; i < 12; i++) begin
            rop = ops[$urandom_range(0, 9)];
            ra  = $urandom;
            rb  = $urandom;
            issue(rop, ra, rb);
            wait_resp($sformatf("rnd%0d_op%0h", i, rop), (i % 4 == 0) ? 3 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
